// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and
// the requester-select values used by the arbiter and the datapath.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        SEL_IC = 1'b0,
        SEL_DC = 1'b1
    } sel_t;

    // Wait counter is sized for the largest legal MAX_WAIT (255).
    localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-input round-robin grant. When both sides request, the side that
// did not win last time is chosen; last_grant resets to the I-cache so
// the D-cache wins the first contested grant.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_ic,
    input  logic i_req_dc,
    input  logic i_grant_en,
    output sel_t o_sel
);

    sel_t r_last;
    sel_t w_sel;

    // Grant selection from the current requests and the last winner.
    always_comb begin
        w_sel = SEL_IC;
        if (i_req_ic && i_req_dc) begin
            w_sel = (r_last == SEL_IC) ? SEL_DC : SEL_IC;
        end else if (i_req_dc) begin
            w_sel = SEL_DC;
        end
    end

    // Remember the winner of every grant actually taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= SEL_IC;
        end else if (i_grant_en && (i_req_ic || i_req_dc)) begin
            r_last <= w_sel;
        end
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fill reads and D-cache reads/writes onto a single
// memory port. One access at a time: IDLE grants and latches the request,
// BUSY holds the memory bus until mem_done or a wait timeout, RESP pulses
// the granted side's ready for one cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int MAX_WAIT = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ic_req,
    input  logic [AW-1:0] ic_addr,
    output logic          ic_ready,
    output logic [15:0]   ic_rdata,
    input  logic          dc_req,
    input  logic          dc_wr,
    input  logic [AW-1:0] dc_addr,
    input  logic [15:0]   dc_wdata,
    output logic          dc_ready,
    output logic [15:0]   dc_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_done,
    output logic          bus_err
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_t            r_state;
    state_t            w_next;
    logic              w_mem_en;
    logic              w_any_req;
    logic              w_timeout;
    sel_t              w_sel;
    sel_t              r_sel;
    logic              r_wr;
    logic [AW-1:0]     r_addr;
    logic [15:0]       r_wdata;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_ic_ready;
    logic              r_dc_ready;
    logic              r_bus_err;
    logic [15:0]       r_ic_rdata;
    logic [15:0]       r_dc_rdata;

    assign w_any_req = ic_req || dc_req;
    // Timeout fires on the BUSY cycle where the counter has already
    // reached MAX_WAIT and memory still has not answered.
    assign w_timeout = (r_state == ST_BUSY) && !mem_done && (r_cnt == MAX_WAIT_C);

    arb_rr2 u_arb (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_req_ic   (ic_req),
        .i_req_dc   (dc_req),
        .i_grant_en (r_state == ST_IDLE),
        .o_sel      (w_sel)
    );

    // FSM state register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory-enable decode.
    always_comb begin
        w_next   = r_state;
        w_mem_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_mem_en = 1'b1;
                if (mem_done || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel      <= SEL_IC;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            r_bus_err  <= 1'b0;
            r_ic_rdata <= '0;
            r_dc_rdata <= '0;
        end else begin
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_sel   <= w_sel;
                        r_cnt   <= '0;
                        r_addr  <= (w_sel == SEL_DC) ? dc_addr : ic_addr;
                        r_wr    <= (w_sel == SEL_DC) ? dc_wr : 1'b0;
                        r_wdata <= (w_sel == SEL_DC) ? dc_wdata : 16'h0000;
                    end
                end
                ST_BUSY: begin
                    if (mem_done || w_timeout) begin
                        r_ic_ready <= (r_sel == SEL_IC);
                        r_dc_ready <= (r_sel == SEL_DC);
                        r_bus_err  <= w_timeout;
                        if (w_timeout || !r_wr) begin
                            if (r_sel == SEL_IC) begin
                                r_ic_rdata <= w_timeout ? 16'h0000 : mem_rdata;
                            end else begin
                                r_dc_rdata <= w_timeout ? 16'h0000 : mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_en    = w_mem_en;
    assign mem_wr    = w_mem_en & r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign ic_ready  = r_ic_ready;
    assign dc_ready  = r_dc_ready;
    assign ic_rdata  = r_ic_rdata;
    assign dc_rdata  = r_dc_rdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Expected accesses are queued in grant
// order when requests are raised; a small memory responder answers from
// the queue head and completions are popped and compared.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_ready;
    logic [15:0]   ic_rdata;
    logic          dc_req;
    logic          dc_wr;
    logic [AW-1:0] dc_addr;
    logic [15:0]   dc_wdata;
    logic          dc_ready;
    logic [15:0]   dc_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          mem_done;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .ic_rdata  (ic_rdata),
        .dc_req    (dc_req),
        .dc_wr     (dc_wr),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_ready  (dc_ready),
        .dc_rdata  (dc_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .bus_err   (bus_err)
    );

    // sel: 0 = I-cache, 1 = D-cache. err=1 means memory never answers.
    typedef struct {
        logic        sel;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          delay;
    } exp_t;

    exp_t q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   rise_cyc = 0;
    int   ic_left  = 0;
    int   dc_left  = 0;
    bit   stray    = 1'b0;

    function automatic exp_t mk(input logic sel, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rdata,
                                input logic err, input int delay);
        exp_t e;
        e.sel = sel; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.err = err; e.delay = delay;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: sample at the falling edge, answer memory, score completions.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (mem_en) begin
            busy_cnt++;
            if (busy_cnt == 1) rise_cyc = cyc;
            if (q.size() == 0) begin
                chk("spurious_grant", 32'(mem_en), 32'd0);
                mem_done = 1'b0;
            end else begin
                chk("mem_wr", 32'(mem_wr), 32'(q[0].wr));
                chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
                if (q[0].wr) chk("mem_wdata", 32'(mem_wdata), 32'(q[0].wdata));
                mem_done  = !q[0].err && (busy_cnt == q[0].delay + 1);
                mem_rdata = mem_done ? q[0].rdata : 16'h5A5A;
            end
        end else begin
            busy_cnt = 0;
            mem_done = 1'b0;
        end
        if (ic_ready || dc_ready) begin
            if (q.size() == 0) begin
                chk("spurious_ready", 32'({ic_ready, dc_ready}), 32'd0);
            end else begin
                e = q.pop_front();
                chk("ic_ready", 32'(ic_ready), 32'(e.sel == 1'b0));
                chk("dc_ready", 32'(dc_ready), 32'(e.sel == 1'b1));
                chk("bus_err", 32'(bus_err), 32'(e.err));
                chk("mem_en_in_resp", 32'(mem_en), 32'd0);
                chk("latency", 32'(cyc - rise_cyc), 32'(e.err ? MAXW + 1 : e.delay + 1));
                if (!e.wr || e.err)
                    chk("rdata", 32'(e.sel ? dc_rdata : ic_rdata), 32'(e.err ? 16'h0000 : e.rdata));
                if (e.sel) begin
                    dc_left--;
                    if (dc_left == 0) dc_req = 1'b0;
                end else begin
                    ic_left--;
                    if (ic_left == 0) ic_req = 1'b0;
                end
                if (stray) begin
                    mem_done  = 1'b1;
                    mem_rdata = 16'hDEAD;
                end
            end
        end
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && !ic_req && !dc_req) break;
            step();
        end
        chk(tag, 32'(q.size() == 0 && !ic_req && !dc_req), 32'd1);
    endtask

    initial begin
        rst = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_wr = 1'b0;
        dc_addr = '0; dc_wdata = '0; mem_rdata = '0; mem_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_readies", 32'({ic_ready, dc_ready, bus_err}), 32'd0);
        chk("rst_rdata", 32'({ic_rdata, dc_rdata}), 32'd0);
        rst = 1'b1;
        step();

        // Simultaneous first requests after reset: D-cache write wins.
        dc_req = 1'b1; dc_wr = 1'b1; dc_addr = 16'h0100; dc_wdata = 16'h1234; dc_left = 1;
        ic_req = 1'b1; ic_addr = 16'h0080; ic_left = 1;
        q.push_back(mk(1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b0, 1));
        q.push_back(mk(1'b0, 1'b0, 16'h0080, 16'h0000, 16'h1111, 1'b0, 0));
        run_until_idle("simul_done", 40);

        // I-cache only, with a stray mem_done during RESP.
        stray = 1'b1;
        ic_req = 1'b1; ic_addr = 16'h0040; ic_left = 1;
        q.push_back(mk(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 2));
        run_until_idle("iconly_done", 40);
        stray = 1'b0;
        step();
        chk("stray_resp_ic_rdata", 32'(ic_rdata), 32'h0000BEEF);
        chk("stray_resp_dc_rdata", 32'(dc_rdata), 32'h00000000);

        // Stray completions while idle.
        for (int i = 0; i < 3; i++) begin
            mem_done = 1'b1; mem_rdata = 16'hDEAD;
            step();
            chk("stray_idle_mem_en", 32'(mem_en), 32'd0);
        end
        chk("stray_idle_ic_rdata", 32'(ic_rdata), 32'h0000BEEF);
        chk("stray_idle_dc_rdata", 32'(dc_rdata), 32'h00000000);

        // Fairness: both keep requesting for three reads each -> D,I,D,I,D,I.
        dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0200; dc_left = 3;
        ic_req = 1'b1; ic_addr = 16'h0300; ic_left = 3;
        for (int k = 0; k < 3; k++) begin
            q.push_back(mk(1'b1, 1'b0, 16'h0200, 16'h0000, 16'hD000 + 16'(k), 1'b0, k));
            q.push_back(mk(1'b0, 1'b0, 16'h0300, 16'h0000, 16'hA000 + 16'(k), 1'b0, 3 - k));
        end
        run_until_idle("rr_done", 100);

        // Timeout on a D-cache read: ready and bus_err together, rdata zero.
        dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0400; dc_left = 1;
        q.push_back(mk(1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 0));
        run_until_idle("timeout_done", 40);
        step();
        chk("post_timeout_bus_err", 32'(bus_err), 32'd0);

        // Reset in the second BUSY cycle abandons the access.
        dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0500; dc_left = 1;
        q.push_back(mk(1'b1, 1'b0, 16'h0500, 16'h0000, 16'h7777, 1'b0, 10));
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy_cnt == 2) break;
        end
        chk("rst_reach_busy2", 32'(busy_cnt), 32'd2);
        rst = 1'b0;
        #1;
        chk("rst_async_mem_en", 32'(mem_en), 32'd0);
        q.delete();
        dc_req = 1'b0; ic_req = 1'b0; dc_left = 0; ic_left = 0; mem_done = 1'b0;
        repeat (3) step();
        chk("rst_hold_readies", 32'({ic_ready, dc_ready, bus_err}), 32'd0);
        chk("rst_hold_dc_rdata", 32'(dc_rdata), 32'd0);
        rst = 1'b1;
        step();
        dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0600; dc_left = 1;
        ic_req = 1'b1; ic_addr = 16'h0700; ic_left = 1;
        q.push_back(mk(1'b1, 1'b0, 16'h0600, 16'h0000, 16'h6666, 1'b0, 1));
        q.push_back(mk(1'b0, 1'b0, 16'h0700, 16'h0000, 16'h5555, 1'b0, 1));
        run_until_idle("post_rst_done", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 16: address width in bits.
REQ-002 Parameter MAX_WAIT, 31: maximum BUSY cycles before timeout; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 ic_req  in  1  I-cache fill read request; held with ic_addr until ic_ready.
REQ-006 ic_addr  in  AW  I-cache read address.
REQ-007 ic_ready  out  1  one-cycle completion pulse to the I-cache.
REQ-008 ic_rdata  out  16  I-cache read data; valid while ic_ready=1.
REQ-009 dc_req  in  1  D-cache request; held with dc_wr, dc_addr and dc_wdata until dc_ready.
REQ-010 dc_wr  in  1  D-cache request type: 1=write, 0=read.
REQ-011 dc_addr  in  AW  D-cache address.
REQ-012 dc_wdata  in  16  D-cache write data.
REQ-013 dc_ready  out  1  one-cycle completion pulse to the D-cache.
REQ-014 dc_rdata  out  16  D-cache read data; valid while dc_ready=1.
REQ-015 mem_en  out  1  memory access active.
REQ-016 mem_wr  out  1  memory write when mem_en=1.
REQ-017 mem_addr  out  AW  memory address.
REQ-018 mem_wdata  out  16  memory write data.
REQ-019 mem_rdata  in  16  memory read data; valid with mem_done.
REQ-020 mem_done  in  1  memory completion strobe.
REQ-021 bus_err  out  1  one-cycle timeout pulse; coincident with the ready pulse it accompanies.

Function
REQ-022 FSM states: IDLE, BUSY, RESP.
REQ-023 IDLE with any request pending: select a requester, latch its addr/wdata/wr into registers, go to BUSY.
REQ-024 IDLE with no request pending: remain in IDLE.
REQ-025 Arbitration: round-robin on a last_grant bit.
- Both requesting: grant the side other than last_grant.
- One requesting: grant that side.
- last_grant updates at every grant.
REQ-026 BUSY: mem_en=1. mem_addr, mem_wdata and mem_wr are driven from the latched registers and stay stable for the whole of BUSY. I-cache grants always drive mem_wr=0.
REQ-027 BUSY with mem_done=1: register mem_rdata into the granted side's rdata register (reads only), go to RESP.
REQ-028 mem_done is ignored outside BUSY.
REQ-029 BUSY wait counter:
- Cleared on entry to BUSY.
- Increments each BUSY cycle without mem_done.
- On reaching MAX_WAIT: go to RESP with bus_err=1 and rdata forced to 0.
REQ-030 RESP:
- Granted side's ready=1 for exactly one cycle; mem_en=0.
- Next state is always IDLE.
- Requests are not sampled in RESP, so a requester dropping req after ready is never re-granted.
REQ-031 Minimum latency: req seen in IDLE at cycle N; mem_en high at N+1; mem_done at cycle M≥N+1; ready at M+1. Back-to-back grants are at least 3 cycles apart.
REQ-032 Ungranted side's ready, rdata and bus_err stay 0.
REQ-033 If req drops while BUSY (protocol violation), the access still completes and ready still pulses.

Reset
REQ-034 rst=0 asynchronously forces:
- state to IDLE;
- mem_en, mem_wr, ic_ready, dc_ready and bus_err to 0;
- mem_addr, mem_wdata, ic_rdata, dc_rdata and the wait counter to 0;
- last_grant to I-cache, so the D-cache wins the first simultaneous request.
REQ-035 Reset asserted mid-BUSY abandons the access: mem_en drops immediately and no ready pulse is generated.

Structure
REQ-036 Shared package: the FSM state encoding and the requester-select encoding (SEL_IC=0, SEL_DC=1).
REQ-037 One sub-module, arb_rr2: a 2-input round-robin grant with the last_grant register. All else stays flat.

Verification
REQ-038 I-cache-only case.
- Stimulus: ic_req=1, ic_addr=0x0040; mem_done 2 cycles after mem_en rises, mem_rdata=0xBEEF.
- Response: mem_wr=0, mem_addr=0x0040; one ic_rdata=0xBEEF with ic_ready pulse; dc_ready stays 0.
REQ-039 Simultaneous requests first after reset.
- Stimulus: ic_req and dc_req (write, addr 0x0100, wdata 0x1234) asserted together.
- Response: D-cache granted first (mem_wr=1, mem_wdata=0x1234); I-cache granted on the next IDLE.
REQ-040 Round-robin fairness.
- Stimulus: both requesters reassert continuously for 6 transactions.
- Response: grant order D,I,D,I,D,I.
REQ-041 Timeout.
- Stimulus: MAX_WAIT=4; dc read; mem_done never asserted.
- Response: dc_ready and bus_err pulse together 5 cycles after mem_en rises; dc_rdata=0.
REQ-042 Reset mid-access.
- Stimulus: rst=0 in the second BUSY cycle.
- Response: mem_en=0 in the same cycle with no clock edge; no ready pulse; first grant after release goes to D.
REQ-043 Stray completion.
- Stimulus: mem_done pulsed while in IDLE and while in RESP.
- Response: no state change, no ready pulse, no rdata update.
